// File: rtl/iopmp_pkg.sv
// Shared TL-UL bus types and IOPMP check types used by the request gate.
package iopmp_pkg;

    localparam int SourceWidth = 8;
    localparam int TlAw        = 32;
    localparam int TlDw        = 32;
    localparam int TlDbw       = 4;
    localparam int TlSzw       = 2;

    localparam logic [2:0] PutFullData    = 3'h0;
    localparam logic [2:0] PutPartialData = 3'h1;
    localparam logic [2:0] Get            = 3'h4;

    localparam logic [2:0] AccessAck      = 3'h0;
    localparam logic [2:0] AccessAckData  = 3'h1;

    typedef struct packed {
        logic                   a_valid;
        logic [2:0]             a_opcode;
        logic [2:0]             a_param;
        logic [TlSzw-1:0]       a_size;
        logic [SourceWidth-1:0] a_source;
        logic [TlAw-1:0]        a_address;
        logic [TlDbw-1:0]       a_mask;
        logic [TlDw-1:0]        a_data;
        logic                   d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic                   d_valid;
        logic [2:0]             d_opcode;
        logic [2:0]             d_param;
        logic [TlSzw-1:0]       d_size;
        logic [SourceWidth-1:0] d_source;
        logic [0:0]             d_sink;
        logic [TlDw-1:0]        d_data;
        logic                   d_error;
        logic                   a_ready;
    } tl_d2h_t;

    typedef enum logic [1:0] {
        IOPMP_ACC_NONE  = 2'd0,
        IOPMP_ACC_READ  = 2'd1,
        IOPMP_ACC_WRITE = 2'd2
    } iopmp_req_e;

    typedef struct packed {
        logic rre;
        logic rwe;
    } err_cfg;

endpackage

// File: rtl/iopmp_req_gate_tlul_if.sv
// Bundle of master/slave TL-UL channels and the permission-check handshake
// for every channel of the request gate.
interface iopmp_req_gate_tlul_if #(
    parameter int NumChan   = 2,
    parameter int AddrWidth = 34
);
    iopmp_pkg::tl_h2d_t    [NumChan-1:0]                             mst_req;
    iopmp_pkg::tl_d2h_t    [NumChan-1:0]                             mst_rsp;
    iopmp_pkg::tl_h2d_t    [NumChan-1:0]                             slv_req;
    iopmp_pkg::tl_d2h_t    [NumChan-1:0]                             slv_rsp;
    logic                  [NumChan-1:0]                             chk_valid;
    logic                  [NumChan-1:0][AddrWidth-1:0]              chk_addr;
    iopmp_pkg::iopmp_req_e [NumChan-1:0]                             chk_access;
    logic                  [NumChan-1:0][iopmp_pkg::SourceWidth-1:0] chk_rrid;
    logic                  [NumChan-1:0]                             chk_done;
    logic                  [NumChan-1:0]                             chk_deny;
    iopmp_pkg::err_cfg                                               err_cfg;
    logic                  [NumChan-1:0]                             viol;

    // Gate side of the bundle.
    modport slave (
        input  mst_req, slv_rsp, chk_done, chk_deny, err_cfg,
        output mst_rsp, slv_req, chk_valid, chk_addr, chk_access, chk_rrid, viol
    );

    // Environment side: masters, slaves and the permission checker.
    modport master (
        output mst_req, slv_rsp, chk_done, chk_deny, err_cfg,
        input  mst_rsp, slv_req, chk_valid, chk_addr, chk_access, chk_rrid, viol
    );
endinterface

// File: rtl/iopmp_req_gate_tlul.sv
// Purpose: per-channel TL-UL request gate; each A request is permission-checked before forwarding.
// Latency: master handshake to slave a_valid = 1 cycle + check latency; D channel is combinational pass-through.
// Backpressure: a_ready drops while a request is in flight or MaxOutstanding responses are pending.
module iopmp_req_gate_tlul
    import iopmp_pkg::*;
#(
    parameter int NumChan        = 2,
    parameter int AddrWidth      = 34,
    parameter int MaxOutstanding = 4
) (
    input logic                  clk_i,
    input logic                  rst_ni,
    iopmp_req_gate_tlul_if.slave bus
);

    typedef enum logic [2:0] {IDLE, CHECK, FWD, DRAIN, ERR_RSP} state_e;

    typedef struct packed {
        logic [2:0]             opcode;
        logic [2:0]             param;
        logic [TlSzw-1:0]       size;
        logic [SourceWidth-1:0] source;
        logic [TlAw-1:0]        address;
        logic [TlDbw-1:0]       mask;
        logic [TlDw-1:0]        data;
    } areq_t;

    localparam logic [3:0] MaxCnt = 4'(MaxOutstanding);

    state_e     state_q [NumChan];
    state_e     state_d [NumChan];
    logic [3:0] cnt_q   [NumChan];
    logic [3:0] cnt_d   [NumChan];
    areq_t      lat_q   [NumChan];
    areq_t      lat_d   [NumChan];

    tl_d2h_t    [NumChan-1:0]                  mst_rsp;
    tl_h2d_t    [NumChan-1:0]                  slv_req;
    logic       [NumChan-1:0]                  chk_valid;
    logic       [NumChan-1:0][AddrWidth-1:0]   chk_addr;
    iopmp_req_e [NumChan-1:0]                  chk_access;
    logic       [NumChan-1:0][SourceWidth-1:0] chk_rrid;
    logic       [NumChan-1:0]                  viol;
    logic       [NumChan-1:0]                  inc;
    logic       [NumChan-1:0]                  dec;

    function automatic logic is_put(input logic [2:0] op);
        return (op == PutFullData) || (op == PutPartialData);
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < NumChan; c++) begin
                state_q[c] <= IDLE;
                cnt_q[c]   <= '0;
                lat_q[c]   <= '0;
            end
        end else begin
            for (int c = 0; c < NumChan; c++) begin
                state_q[c] <= state_d[c];
                cnt_q[c]   <= cnt_d[c];
                lat_q[c]   <= lat_d[c];
            end
        end
    end

    always_comb begin
        mst_rsp    = '0;
        slv_req    = '0;
        chk_valid  = '0;
        chk_addr   = '0;
        chk_access = {NumChan{IOPMP_ACC_NONE}};
        chk_rrid   = '0;
        viol       = '0;
        inc        = '0;
        dec        = '0;
        for (int c = 0; c < NumChan; c++) begin
            state_d[c] = state_q[c];
            cnt_d[c]   = cnt_q[c];
            lat_d[c]   = lat_q[c];

            // The D channel belongs to the slave except while the gate answers itself.
            if (state_q[c] != ERR_RSP) begin
                mst_rsp[c]         = bus.slv_rsp[c];
                mst_rsp[c].a_ready = 1'b0;
                slv_req[c].d_ready = bus.mst_req[c].d_ready;
            end

            unique case (state_q[c])
                IDLE: begin
                    mst_rsp[c].a_ready = (cnt_q[c] < MaxCnt);
                    if (bus.mst_req[c].a_valid && (cnt_q[c] < MaxCnt)) begin
                        lat_d[c].opcode  = bus.mst_req[c].a_opcode;
                        lat_d[c].param   = bus.mst_req[c].a_param;
                        lat_d[c].size    = bus.mst_req[c].a_size;
                        lat_d[c].source  = bus.mst_req[c].a_source;
                        lat_d[c].address = bus.mst_req[c].a_address;
                        lat_d[c].mask    = bus.mst_req[c].a_mask;
                        lat_d[c].data    = bus.mst_req[c].a_data;
                        state_d[c]       = CHECK;
                    end
                end
                CHECK: begin
                    chk_valid[c]  = 1'b1;
                    chk_addr[c]   = AddrWidth'(lat_q[c].address);
                    chk_access[c] = is_put(lat_q[c].opcode) ? IOPMP_ACC_WRITE : IOPMP_ACC_READ;
                    chk_rrid[c]   = SourceWidth'(c);
                    if (bus.chk_done[c]) begin
                        if (!bus.chk_deny[c]) begin
                            state_d[c] = FWD;
                        end else begin
                            viol[c]    = 1'b1;
                            state_d[c] = (cnt_q[c] == '0) ? ERR_RSP : DRAIN;
                        end
                    end
                end
                FWD: begin
                    slv_req[c].a_valid   = 1'b1;
                    slv_req[c].a_opcode  = lat_q[c].opcode;
                    slv_req[c].a_param   = lat_q[c].param;
                    slv_req[c].a_size    = lat_q[c].size;
                    slv_req[c].a_source  = lat_q[c].source;
                    slv_req[c].a_address = lat_q[c].address;
                    slv_req[c].a_mask    = lat_q[c].mask;
                    slv_req[c].a_data    = lat_q[c].data;
                    if (bus.slv_rsp[c].a_ready) begin
                        inc[c]     = 1'b1;
                        state_d[c] = IDLE;
                    end
                end
                DRAIN: begin
                    if (cnt_q[c] == '0) begin
                        state_d[c] = ERR_RSP;
                    end
                end
                ERR_RSP: begin
                    mst_rsp[c].d_valid  = 1'b1;
                    mst_rsp[c].d_opcode = is_put(lat_q[c].opcode) ? AccessAck : AccessAckData;
                    mst_rsp[c].d_source = lat_q[c].source;
                    mst_rsp[c].d_size   = lat_q[c].size;
                    mst_rsp[c].d_error  = is_put(lat_q[c].opcode) ? !bus.err_cfg.rwe
                                                                  : !bus.err_cfg.rre;
                    if (bus.mst_req[c].d_ready) begin
                        state_d[c] = IDLE;
                    end
                end
                default: state_d[c] = IDLE;
            endcase

            dec[c] = bus.slv_rsp[c].d_valid && slv_req[c].d_ready;
            if (inc[c] && !dec[c] && (cnt_q[c] != 4'hF)) begin
                cnt_d[c] = cnt_q[c] + 4'd1;
            end else if (dec[c] && !inc[c] && (cnt_q[c] != 4'h0)) begin
                cnt_d[c] = cnt_q[c] - 4'd1;
            end
        end

        // Outputs are held quiet while reset is asserted.
        if (!rst_ni) begin
            mst_rsp    = '0;
            slv_req    = '0;
            chk_valid  = '0;
            chk_addr   = '0;
            chk_access = {NumChan{IOPMP_ACC_NONE}};
            chk_rrid   = '0;
            viol       = '0;
        end
    end

    assign bus.mst_rsp    = mst_rsp;
    assign bus.slv_req    = slv_req;
    assign bus.chk_valid  = chk_valid;
    assign bus.chk_addr   = chk_addr;
    assign bus.chk_access = chk_access;
    assign bus.chk_rrid   = chk_rrid;
    assign bus.viol       = viol;

endmodule
